seq_divider: RTL and testbench

- Iterative unsigned restoring divider.
- Inverse datapath to the team's 8x8 Wallace multiplier: it takes a 2W-bit product-width dividend and a W-bit divisor, and returns a W-bit quotient and a W-bit remainder.
- Computes one quotient bit per clock.
- Sits behind the arithmetic unit's operand registers, with a valid/ready handshake on both sides.

---
 rtl/seq_divider.sv | 178 +++++++++++++++++
 tb/tb_seq_divider.sv | 375 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/seq_divider.sv
// -----------------------------------------------------------------------------
// seq_divider
//   Iterative unsigned restoring divider. It divides a 2W-bit dividend by a
//   W-bit divisor and produces a W-bit quotient and a W-bit remainder, one
//   quotient bit per clock. It is the inverse of the 8x8 Wallace multiplier
//   path.
//
//   Handshake: a transfer happens on a rising clock edge where valid and ready
//   are both high. in_ready is high only in IDLE, so at most one operation is
//   in flight. Once out_valid is high, the result and flags stay stable until
//   the edge where out_ready is also high.
//
//   Optional feature (macro SEQ_DIVIDER_ABORT_EN): adds an 'abort' input.
//   When abort is high in CALC or DONE, the block returns to IDLE and drops the
//   result. The result registers keep their previous values. The default build
//   has no abort port.
//
// Ports
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset
//   in_valid     operands valid
//   in_ready     block can accept operands (IDLE only)
//   dividend     2W-bit unsigned dividend
//   divisor      W-bit unsigned divisor
//   out_valid    result valid
//   out_ready    consumer accepts result
//   quotient     W-bit quotient
//   remainder    W-bit remainder
//   div_by_zero  divisor was zero (qualified by out_valid)
//   overflow     quotient does not fit in W bits (qualified by out_valid)
//   abort        abandon current operation (SEQ_DIVIDER_ABORT_EN only)
//   state_dbg    current FSM state (IDLE=0, CALC=1, DONE=2)
// -----------------------------------------------------------------------------
module seq_divider #(
  parameter int W = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [2*W-1:0] dividend,
  input  logic [W-1:0]   divisor,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [W-1:0]   quotient,
  output logic [W-1:0]   remainder,
  output logic           div_by_zero,
  output logic           overflow,
`ifdef SEQ_DIVIDER_ABORT_EN
  input  logic           abort,
`endif
  output logic [1:0]     state_dbg
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int SW = (W > 1) ? $clog2(W) : 1;

  state_t          state_q;
  logic [W:0]      r_q;          // partial remainder, one guard bit
  logic [W-1:0]    q_q;          // dividend low half shifting out, quotient shifting in
  logic [W-1:0]    divisor_q;
  logic [SW-1:0]   step_q;
  logic [W-1:0]    quotient_q;
  logic [W-1:0]    remainder_q;
  logic            dbz_q;
  logic            ovf_q;
  logic            out_valid_q;

  // One restoring step. The overflow pre-check keeps R below the divisor, so
  // R[W] is always 0 before the shift and the shifted value fits in W+1 bits.
  // The extra top bit of the subtraction is the borrow.
  logic [W:0]   r_shift;
  logic [W+1:0] t_diff;
  logic         borrow;
  logic [W:0]   r_d;
  logic [W-1:0] q_d;

  always_comb begin
    r_shift = {r_q[W-1:0], q_q[W-1]};
    t_diff  = {1'b0, r_shift} - {2'b00, divisor_q};
    borrow  = t_diff[W+1];
    r_d     = borrow ? r_shift : t_diff[W:0];
    q_d     = {q_q[W-2:0], ~borrow};
  end

  logic abort_w;
`ifdef SEQ_DIVIDER_ABORT_EN
  assign abort_w = abort;
`else
  assign abort_w = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      r_q         <= '0;
      q_q         <= '0;
      divisor_q   <= '0;
      step_q      <= '0;
      quotient_q  <= '0;
      remainder_q <= '0;
      dbz_q       <= 1'b0;
      ovf_q       <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          // abort is ignored here, and a simultaneous in_valid is still accepted.
          if (in_valid) begin
            divisor_q <= divisor;
            if (divisor == '0) begin
              quotient_q  <= '1;
              remainder_q <= dividend[W-1:0];
              dbz_q       <= 1'b1;
              ovf_q       <= 1'b0;
              out_valid_q <= 1'b1;
              state_q     <= DONE;
            end else if (dividend[2*W-1:W] >= divisor) begin
              quotient_q  <= '1;
              remainder_q <= '0;
              dbz_q       <= 1'b0;
              ovf_q       <= 1'b1;
              out_valid_q <= 1'b1;
              state_q     <= DONE;
            end else begin
              r_q     <= {1'b0, dividend[2*W-1:W]};
              q_q     <= dividend[W-1:0];
              step_q  <= '0;
              dbz_q   <= 1'b0;
              ovf_q   <= 1'b0;
              state_q <= CALC;
            end
          end
        end
        CALC: begin
          if (abort_w) begin
            state_q <= IDLE;
          end else begin
            r_q    <= r_d;
            q_q    <= q_d;
            step_q <= step_q + SW'(1);
            if (step_q == SW'(W-1)) begin
              quotient_q  <= q_d;
              remainder_q <= r_d[W-1:0];
              out_valid_q <= 1'b1;
              state_q     <= DONE;
            end
          end
        end
        DONE: begin
          // abort has priority over the result handshake.
          if (abort_w || out_ready) begin
            out_valid_q <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: begin
          out_valid_q <= 1'b0;
          state_q     <= IDLE;
        end
      endcase
    end
  end

  assign in_ready    = (state_q == IDLE);
  assign out_valid   = out_valid_q;
  assign quotient    = quotient_q;
  assign remainder   = remainder_q;
  assign div_by_zero = dbz_q;
  assign overflow    = ovf_q;
  assign state_dbg   = state_q;

endmodule

// File: tb/tb_seq_divider.sv
// -----------------------------------------------------------------------------
// tb_seq_divider
//   Directed and randomized bench for seq_divider (W=8). Inputs are driven and
//   outputs are sampled 1 ns after each rising edge.
// -----------------------------------------------------------------------------
module tb_seq_divider;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] dividend;
  logic [7:0]  divisor;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  quotient;
  logic [7:0]  remainder;
  logic        div_by_zero;
  logic        overflow;
  logic [1:0]  state_dbg;
`ifdef SEQ_DIVIDER_ABORT_EN
  logic        abort;
`endif

  int checks = 0;
  int failures = 0;

  // {div_by_zero, overflow, quotient, remainder}
  logic [17:0] exp_q[$];

  seq_divider #(.W(8)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .dividend    (dividend),
    .divisor     (divisor),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero),
    .overflow    (overflow),
`ifdef SEQ_DIVIDER_ABORT_EN
    .abort       (abort),
`endif
    .state_dbg   (state_dbg)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- driver tasks ----------------
  // Presents one operation and waits for out_valid. lat is the number of edges
  // after the accepting edge until out_valid was seen. out_ready is left as
  // the caller set it.
  task automatic run_op(input logic [15:0] dd, input logic [7:0] dv,
                        output int lat, output bit ok);
    int guard;
    ok = 1'b1;
    guard = 0;
    in_valid = 1'b1;
    dividend = dd;
    divisor  = dv;
    while (!in_ready && guard < 50) begin
      @(posedge clk); #1;
      guard++;
    end
    if (!in_ready) ok = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 50) begin
      @(posedge clk); #1;
      lat++;
    end
    if (!out_valid) ok = 1'b0;
  endtask

  task automatic complete_op();
    out_ready = 1'b1;
    @(posedge clk); #1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    in_valid = 1'b0; dividend = '0; divisor = '0; out_ready = 1'b1;
`ifdef SEQ_DIVIDER_ABORT_EN
    abort = 1'b0;
`endif
    @(posedge clk); #1;
    checks++;
    if ({state_dbg, in_ready, out_valid, quotient, remainder, div_by_zero, overflow}
        !== {2'd0, 1'b1, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0}) begin
      failures++;
      $display("FAIL reset_state: got st=%0d ir=%b ov=%b q=%h r=%h dbz=%b ovf=%b, expected st=0 ir=1 ov=0 q=00 r=00 dbz=0 ovf=0",
               state_dbg, in_ready, out_valid, quotient, remainder, div_by_zero, overflow);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_normal();
    int lat; bit ok;
    out_ready = 1'b1;
    run_op(16'd100, 8'd7, lat, ok);
    checks++;
    if (!ok || lat != 8) begin
      failures++;
      $display("FAIL normal_latency: got ok=%b lat=%0d, expected ok=1 lat=8", ok, lat);
    end
    checks++;
    if ({quotient, remainder, div_by_zero, overflow, in_ready} !== {8'd14, 8'd2, 1'b0, 1'b0, 1'b0}) begin
      failures++;
      $display("FAIL normal_result: got q=%0d r=%0d dbz=%b ovf=%b ir=%b, expected q=14 r=2 dbz=0 ovf=0 ir=0",
               quotient, remainder, div_by_zero, overflow, in_ready);
    end
    complete_op();
    checks++;
    if ({out_valid, in_ready} !== 2'b01) begin
      failures++;
      $display("FAIL normal_release: got ov=%b ir=%b, expected ov=0 ir=1", out_valid, in_ready);
    end
  endtask

  task automatic test_full_range();
    int lat; bit ok;
    out_ready = 1'b1;
    run_op(16'hFE01, 8'hFF, lat, ok);
    checks++;
    if (!ok || {quotient, remainder, div_by_zero, overflow} !== {8'hFF, 8'h00, 1'b0, 1'b0}) begin
      failures++;
      $display("FAIL full_fe01_ff: got ok=%b q=%h r=%h dbz=%b ovf=%b, expected q=ff r=00 dbz=0 ovf=0",
               ok, quotient, remainder, div_by_zero, overflow);
    end
    complete_op();
    run_op(16'h00FE, 8'h01, lat, ok);
    checks++;
    if (!ok || {quotient, remainder, div_by_zero, overflow} !== {8'hFE, 8'h00, 1'b0, 1'b0}) begin
      failures++;
      $display("FAIL full_00fe_01: got ok=%b q=%h r=%h dbz=%b ovf=%b, expected q=fe r=00 dbz=0 ovf=0",
               ok, quotient, remainder, div_by_zero, overflow);
    end
    complete_op();
  endtask

  // For error cases out_valid is already high in the cycle right after the
  // accepting edge, so the extra-edge count is 0.
  task automatic test_errors();
    int lat; bit ok;
    out_ready = 1'b1;
    run_op(16'h04D2, 8'h00, lat, ok);
    checks++;
    if (!ok || lat != 0 || {quotient, remainder, div_by_zero, overflow} !== {8'hFF, 8'hD2, 1'b1, 1'b0}) begin
      failures++;
      $display("FAIL div_by_zero: got ok=%b lat=%0d q=%h r=%h dbz=%b ovf=%b, expected lat=0 q=ff r=d2 dbz=1 ovf=0",
               ok, lat, quotient, remainder, div_by_zero, overflow);
    end
    complete_op();
    run_op(16'h1234, 8'h12, lat, ok);
    checks++;
    if (!ok || lat != 0 || {quotient, remainder, div_by_zero, overflow} !== {8'hFF, 8'h00, 1'b0, 1'b1}) begin
      failures++;
      $display("FAIL overflow: got ok=%b lat=%0d q=%h r=%h dbz=%b ovf=%b, expected lat=0 q=ff r=00 dbz=0 ovf=1",
               ok, lat, quotient, remainder, div_by_zero, overflow);
    end
    complete_op();
  endtask

  task automatic test_backpressure();
    int lat; bit ok;
    out_ready = 1'b0;
    run_op(16'd100, 8'd7, lat, ok);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL bp_start: got ok=%b, expected ok=1", ok);
    end
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      dividend = 16'd50;
      divisor  = 8'd3;
      @(posedge clk); #1;
      checks++;
      if ({out_valid, in_ready, quotient, remainder, div_by_zero, overflow}
          !== {1'b1, 1'b0, 8'd14, 8'd2, 1'b0, 1'b0}) begin
        failures++;
        $display("FAIL bp_stall_%0d: got ov=%b ir=%b q=%0d r=%0d dbz=%b ovf=%b, expected ov=1 ir=0 q=14 r=2 dbz=0 ovf=0",
                 i, out_valid, in_ready, quotient, remainder, div_by_zero, overflow);
      end
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    checks++;
    if ({out_valid, in_ready, quotient, remainder} !== {1'b0, 1'b1, 8'd14, 8'd2}) begin
      failures++;
      $display("FAIL bp_release: got ov=%b ir=%b q=%0d r=%0d, expected ov=0 ir=1 q=14 r=2",
               out_valid, in_ready, quotient, remainder);
    end
  endtask

  task automatic test_reset_mid_calc();
    int lat; bit ok;
    out_ready = 1'b1;
    in_valid = 1'b1;
    dividend = 16'd100;
    divisor  = 8'd7;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    checks++;
    if ({state_dbg, out_valid} !== {2'd1, 1'b0}) begin
      failures++;
      $display("FAIL rst_pre_calc: got st=%0d ov=%b, expected st=1 ov=0", state_dbg, out_valid);
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({state_dbg, in_ready, out_valid, quotient, remainder, div_by_zero, overflow}
        !== {2'd0, 1'b1, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0}) begin
      failures++;
      $display("FAIL rst_async: got st=%0d ir=%b ov=%b q=%h r=%h dbz=%b ovf=%b, expected st=0 ir=1 ov=0 q=00 r=00 dbz=0 ovf=0",
               state_dbg, in_ready, out_valid, quotient, remainder, div_by_zero, overflow);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (out_valid !== 1'b0) begin
      failures++;
      $display("FAIL rst_no_result: got ov=%b, expected ov=0", out_valid);
    end
    run_op(16'd200, 8'd9, lat, ok);
    checks++;
    if (!ok || lat != 8 || {quotient, remainder, div_by_zero, overflow} !== {8'd22, 8'd2, 1'b0, 1'b0}) begin
      failures++;
      $display("FAIL rst_then_200_9: got ok=%b lat=%0d q=%0d r=%0d dbz=%b ovf=%b, expected lat=8 q=22 r=2 dbz=0 ovf=0",
               ok, lat, quotient, remainder, div_by_zero, overflow);
    end
    complete_op();
  endtask

`ifdef SEQ_DIVIDER_ABORT_EN
  // Follows test_reset_mid_calc, so the result registers hold 22 / 2.
  task automatic test_abort();
    bit seen;
    out_ready = 1'b1;
    in_valid = 1'b1;
    dividend = 16'd100;
    divisor  = 8'd7;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    checks++;
    if ({out_valid, in_ready, quotient, remainder} !== {1'b0, 1'b1, 8'd22, 8'd2}) begin
      failures++;
      $display("FAIL abort_calc: got ov=%b ir=%b q=%0d r=%0d, expected ov=0 ir=1 q=22 r=2",
               out_valid, in_ready, quotient, remainder);
    end
    seen = 1'b0;
    repeat (10) begin
      @(posedge clk); #1;
      if (out_valid) seen = 1'b1;
    end
    checks++;
    if (seen !== 1'b0) begin
      failures++;
      $display("FAIL abort_no_result: got out_valid seen=%b, expected 0", seen);
    end
  endtask
`endif

  task automatic test_back_to_back();
    logic [15:0] dd;
    logic [7:0]  dv;
    logic [17:0] exp_v;
    int mode, hi, guard;
    bit got;
    for (int n = 0; n < 1000; n++) begin
      mode = $urandom_range(0, 9);
      if (mode == 0) begin
        dv = 8'h00;
        dd = 16'($urandom_range(0, 65535));
      end else if (mode == 1) begin
        dv = 8'($urandom_range(1, 255));
        dd = {8'($urandom_range(int'(dv), 255)), 8'($urandom_range(0, 255))};
      end else begin
        dv = 8'($urandom_range(1, 255));
        hi = $urandom_range(0, int'(dv) - 1);
        dd = {8'(hi), 8'($urandom_range(0, 255))};
      end
      // Reference model from the arithmetic definition.
      if (dv == 8'h00)
        exp_q.push_back({1'b1, 1'b0, 8'hFF, dd[7:0]});
      else if (dd[15:8] >= dv)
        exp_q.push_back({1'b0, 1'b1, 8'hFF, 8'h00});
      else
        exp_q.push_back({1'b0, 1'b0, 8'(dd / 16'(dv)), 8'(dd % 16'(dv))});

      repeat ($urandom_range(0, 2)) begin
        out_ready = 1'($urandom_range(0, 1));
        @(posedge clk); #1;
      end
      in_valid = 1'b1;
      dividend = dd;
      divisor  = dv;
      @(posedge clk); #1;
      in_valid = 1'b0;
      got = 1'b0;
      guard = 0;
      while (!got && guard < 100) begin
        out_ready = 1'($urandom_range(0, 1));
        // Junk operands while busy must be ignored.
        if ($urandom_range(0, 3) == 0) begin
          in_valid = 1'b1;
          dividend = 16'($urandom);
          divisor  = 8'($urandom);
        end else begin
          in_valid = 1'b0;
        end
        if (out_valid && out_ready) begin
          got = 1'b1;
          exp_v = exp_q.pop_front();
          checks++;
          if ({div_by_zero, overflow, quotient, remainder} !== exp_v) begin
            failures++;
            $display("FAIL b2b_%0d (%h/%h): got dbz=%b ovf=%b q=%h r=%h, expected dbz=%b ovf=%b q=%h r=%h",
                     n, dd, dv, div_by_zero, overflow, quotient, remainder,
                     exp_v[17], exp_v[16], exp_v[15:8], exp_v[7:0]);
          end
        end
        @(posedge clk); #1;
        guard++;
      end
      in_valid = 1'b0;
      if (!got) begin
        checks++;
        failures++;
        void'(exp_q.pop_front());
        $display("FAIL b2b_timeout_%0d: got no result in 100 cycles, expected a result", n);
      end
    end
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    test_reset();
    test_normal();
    test_full_range();
    test_errors();
    test_backpressure();
    test_reset_mid_calc();
`ifdef SEQ_DIVIDER_ABORT_EN
    test_abort();
`endif
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
